// File: rtl/sha2_msg_sched_eddsa.sv
// SHA-2 message schedule: streams in a 16-word block and emits W_0..W_{ROUNDS-1} through a one-deep output register.
// Optional abort input enabled by defining SHA2_SCHED_ABORT_EN.
module sha2_msg_sched_eddsa #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SHA2_SCHED_ABORT_EN
  input  logic             abort,
`endif
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_out,
  output logic [6:0]       w_idx,
  output logic             w_last,
  output logic             busy
);

  localparam int ROUNDS = (MODE == 384 || MODE == 512) ? 80 : 64;
  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} state_e;

  state_e           state_q, state_d;
  logic [6:0]       t_q, t_d;
  logic [WIDTH-1:0] buf_q [16];
  logic             w_valid_q, w_valid_d;
  logic             w_last_q, w_last_d;
  logic [WIDTH-1:0] w_out_q, w_out_d;
  logic [6:0]       w_idx_q, w_idx_d;

  logic             slot_free;
  logic             abort_s;
  logic             shift_en;
  logic [WIDTH-1:0] shift_word;
  logic [WIDTH-1:0] s0, s1, w_new;

`ifdef SHA2_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  // buf_q[15] holds W_{t-1}, buf_q[0] holds W_{t-16}
  if (MODE == 384 || MODE == 512) begin : g_sig512
    assign s0 = rotr(buf_q[1], 1) ^ rotr(buf_q[1], 8) ^ (buf_q[1] >> 7);
    assign s1 = rotr(buf_q[14], 19) ^ rotr(buf_q[14], 61) ^ (buf_q[14] >> 6);
  end else begin : g_sig256
    assign s0 = rotr(buf_q[1], 7) ^ rotr(buf_q[1], 18) ^ (buf_q[1] >> 3);
    assign s1 = rotr(buf_q[14], 17) ^ rotr(buf_q[14], 19) ^ (buf_q[14] >> 10);
  end

  assign w_new     = s1 + buf_q[9] + s0 + buf_q[0];
  assign slot_free = !w_valid_q || w_ready;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    w_valid_d  = w_valid_q;
    w_last_d   = w_last_q;
    w_out_d    = w_out_q;
    w_idx_d    = w_idx_q;
    shift_en   = 1'b0;
    shift_word = w_new;
    m_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort_s) begin
          state_d = ST_LOAD;
          t_d     = '0;
        end
      end
      ST_LOAD: begin
        m_ready = slot_free && (t_q < 7'd16) && !abort_s;
        if (m_ready && m_valid) begin
          w_out_d    = m_data;
          w_idx_d    = t_q;
          w_valid_d  = 1'b1;
          w_last_d   = 1'b0;
          shift_en   = 1'b1;
          shift_word = m_data;
          t_d        = t_q + 7'd1;
          if (t_q == 7'd15) state_d = ST_EXPAND;
        end else if (slot_free) begin
          w_valid_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        if (w_valid_q && w_ready && w_last_q) begin
          state_d   = ST_IDLE;
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
        end else if (slot_free && (t_q <= LAST_IDX)) begin
          w_out_d   = w_new;
          w_idx_d   = t_q;
          w_valid_d = 1'b1;
          w_last_d  = (t_q == LAST_IDX);
          shift_en  = 1'b1;
          t_d       = t_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort wins over any handshake resolved above in the same cycle
    if (abort_s && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      t_d       = '0;
      w_valid_d = 1'b0;
      w_last_d  = 1'b0;
      shift_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      w_out_q   <= '0;
      w_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      w_out_q   <= w_out_d;
      w_idx_q   <= w_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < 15; i++) buf_q[i] <= buf_q[i+1];
      buf_q[15] <= shift_word;
    end
  end

  assign w_valid = w_valid_q;
  assign w_last  = w_last_q;
  assign w_out   = w_out_q;
  assign w_idx   = w_idx_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha2_msg_sched_eddsa.sv
// Directed bench for sha2_msg_sched_eddsa: SHA-256 and SHA-512 "abc" schedules, stalls, reset, ignored start, abort.
module tb_sha2_msg_sched_eddsa;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b, m_valid, w_ready;
  logic [63:0] m_data;
  logic        sel;

  logic        m_ready_a, w_valid_a, w_last_a, busy_a;
  logic [31:0] w_out_a;
  logic [6:0]  w_idx_a;
  logic        m_ready_b, w_valid_b, w_last_b, busy_b;
  logic [63:0] w_out_b;
  logic [6:0]  w_idx_b;
`ifdef SHA2_SCHED_ABORT_EN
  logic        abort_a;
`endif

  sha2_msg_sched_eddsa #(.WIDTH(32), .MODE(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef SHA2_SCHED_ABORT_EN
    .abort(abort_a),
`endif
    .m_valid(m_valid), .m_ready(m_ready_a), .m_data(m_data[31:0]),
    .w_valid(w_valid_a), .w_ready(w_ready), .w_out(w_out_a),
    .w_idx(w_idx_a), .w_last(w_last_a), .busy(busy_a)
  );

  sha2_msg_sched_eddsa #(.WIDTH(64), .MODE(512)) dut512 (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef SHA2_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .m_valid(m_valid), .m_ready(m_ready_b), .m_data(m_data),
    .w_valid(w_valid_b), .w_ready(w_ready), .w_out(w_out_b),
    .w_idx(w_idx_b), .w_last(w_last_b), .busy(busy_b)
  );

  logic        o_wv, o_mrdy, o_wlast, o_busy;
  logic [63:0] o_wout;
  logic [6:0]  o_widx;
  assign o_wv    = sel ? w_valid_b : w_valid_a;
  assign o_mrdy  = sel ? m_ready_b : m_ready_a;
  assign o_wlast = sel ? w_last_b  : w_last_a;
  assign o_busy  = sel ? busy_b    : busy_a;
  assign o_wout  = sel ? w_out_b   : {32'd0, w_out_a};
  assign o_widx  = sel ? w_idx_b   : w_idx_a;

  int passed = 0;
  int total  = 0;

  logic [63:0] blk   [16];
  logic [63:0] expw  [80];
  logic [63:0] col_w [100];
  logic [6:0]  col_idx [100];
  logic        col_last [100];
  int          ncol, stab_err, last_cyc;
  bit          timed_out, stopped;

  function automatic logic [31:0] bs0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction
  function automatic logic [31:0] bs1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction
  function automatic logic [63:0] bs0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'd0, x[63:7]};
  endfunction
  function automatic logic [63:0] bs1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'd0, x[63:6]};
  endfunction

  task automatic build_exp(input bit wide);
    logic [31:0] a;
    for (int i = 0; i < 16; i++) expw[i] = blk[i];
    for (int i = 16; i < 80; i++) begin
      if (wide) begin
        expw[i] = bs1_512(expw[i-2]) + expw[i-7] + bs0_512(expw[i-15]) + expw[i-16];
      end else begin
        a = bs1_256(expw[i-2][31:0]) + expw[i-7][31:0] + bs0_256(expw[i-15][31:0]) + expw[i-16][31:0];
        expw[i] = {32'd0, a};
      end
    end
  endtask

  task automatic set_abc(input bit wide);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = wide ? 64'h6162638000000000 : 64'h0000000061626380;
    blk[15] = 64'h18;
    build_exp(wide);
  endtask

  // Runs one block on the selected DUT, collecting every W handshake.
  task automatic drive(input bit rnd, input int start_m, input int start_w, input int stop_w);
    int          mi = 0;
    bit          done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_out = '0;
    logic [6:0]  prev_idx = '0;
    logic        rdy;
    logic        st;
    ncol = 0; stab_err = 0; last_cyc = -1; timed_out = 1'b0; stopped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      col_w[i] = 'x; col_idx[i] = 'x; col_last[i] = 1'bx;
    end
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall && (o_wv !== 1'b1 || o_wout !== prev_out || o_widx !== prev_idx)) stab_err++;
      if (stop_w >= 0 && o_wv === 1'b1 && o_widx == 7'(stop_w)) begin
        stopped = 1'b1;
        break;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = rdy;
      st = (mi == start_m) || (start_w >= 0 && o_wv === 1'b1 && o_widx == 7'(start_w));
      if (sel) start_b = st; else start_a = st;
      if (mi < 16) begin
        m_valid = 1'b1;
        m_data  = blk[mi];
      end else begin
        m_valid = 1'b0;
        m_data  = 64'hDEADBEEFCAFEF00D;
      end
      #1;
      if (m_valid && o_mrdy === 1'b1) mi++;
      if (o_wv === 1'b1 && rdy) begin
        if (ncol < 100) begin
          col_w[ncol] = o_wout; col_idx[ncol] = o_widx; col_last[ncol] = o_wlast;
        end
        ncol++;
        if (o_wlast === 1'b1) begin
          done = 1'b1;
          last_cyc = cyc;
        end
      end
      prev_stall = (o_wv === 1'b1) && !rdy;
      prev_out = o_wout;
      prev_idx = o_widx;
      if (done || ncol >= 100) break;
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0; m_valid = 1'b0;
    if (!done && !stopped) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    sel = 1'b0; rst_n = 1'b0; m_valid = 1'b1; m_data = 64'h0123456789ABCDEF; w_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({o_wv, o_mrdy, o_wlast, o_busy, w_valid_b, m_ready_b, w_last_b, busy_b} !== 8'h00)
      $display("FAIL reset_flags: got %b want 00000000",
               {o_wv, o_mrdy, o_wlast, o_busy, w_valid_b, m_ready_b, w_last_b, busy_b});
    else passed++;
    total++;
    if (o_wout !== 64'd0 || o_widx !== 7'd0 || w_out_b !== 64'd0 || w_idx_b !== 7'd0)
      $display("FAIL reset_data: got w_out=%h w_idx=%0d w_out512=%h w_idx512=%0d want all 0",
               o_wout, o_widx, w_out_b, w_idx_b);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (o_mrdy !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL idle_no_consume: got m_ready=%b busy=%b want 0 0", o_mrdy, o_busy);
    else passed++;
    m_valid = 1'b0;
  endtask

  task automatic check_full(input string nm, input int rounds, input bit chk_cyc);
    int errs = 0;
    int lerrs = 0;
    total++;
    if (timed_out) $display("FAIL %s_timeout: got no w_last within budget, want completion", nm);
    else passed++;
    total++;
    if (ncol !== rounds) $display("FAIL %s_count: got %0d words want %0d", nm, ncol, rounds);
    else passed++;
    for (int i = 0; i < rounds; i++) begin
      if (col_idx[i] !== 7'(i) || col_w[i] !== expw[i]) errs++;
      if (col_last[i] !== (i == rounds - 1)) lerrs++;
    end
    total++;
    if (errs != 0) $display("FAIL %s_sequence: got %0d bad words (W1=%h) want 0 (W1=%h)", nm, errs, col_w[1], expw[1]);
    else passed++;
    total++;
    if (lerrs != 0) $display("FAIL %s_last: got %0d misplaced w_last want 0", nm, lerrs);
    else passed++;
    if (chk_cyc) begin
      total++;
      if (last_cyc != rounds) $display("FAIL %s_rate: got last word at cycle %0d want %0d", nm, last_cyc, rounds);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (o_wv !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL %s_done: got w_valid=%b busy=%b want 0 0", nm, o_wv, o_busy);
    else passed++;
  endtask

  task automatic test_abc256;
    sel = 1'b0;
    set_abc(1'b0);
    drive(1'b0, -1, -1, -1);
    total++;
    if (col_w[16] !== 64'h61626380 || col_w[17] !== 64'h000f0000)
      $display("FAIL t1_w16_w17: got %h %h want 61626380 000f0000", col_w[16][31:0], col_w[17][31:0]);
    else passed++;
    total++;
    if (col_w[18] !== 64'h7da86405 || col_w[19] !== 64'h600003c6)
      $display("FAIL t1_w18_w19: got %h %h want 7da86405 600003c6", col_w[18][31:0], col_w[19][31:0]);
    else passed++;
    check_full("t1", 64, 1'b1);
  endtask

  task automatic test_stall;
    sel = 1'b0;
    set_abc(1'b0);
    drive(1'b1, -1, -1, -1);
    total++;
    if (stab_err != 0) $display("FAIL t2_stable: got %0d changes while stalled want 0", stab_err);
    else passed++;
    check_full("t2", 64, 1'b0);
  endtask

  task automatic test_abc512;
    int errs = 0;
    sel = 1'b1;
    set_abc(1'b1);
    drive(1'b0, -1, -1, -1);
    for (int i = 0; i < 16; i++) if (col_w[i] !== blk[i]) errs++;
    total++;
    if (errs != 0) $display("FAIL t3_passthru: got %0d words differing from input want 0", errs);
    else passed++;
    total++;
    if (col_w[16] !== 64'h6162638000000000 || col_w[17] !== 64'h00030000000000c0)
      $display("FAIL t3_w16_w17: got %h %h want 6162638000000000 00030000000000c0", col_w[16], col_w[17]);
    else passed++;
    check_full("t3", 80, 1'b1);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int errs = 0;
    sel = 1'b0;
    set_abc(1'b0);
    drive(1'b0, -1, -1, 30);
    total++;
    if (!stopped) $display("FAIL t4_reach30: got w_idx 30 not seen want seen");
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_wv, o_mrdy, o_wlast, o_busy} !== 4'b0000 || o_wout !== 64'd0 || o_widx !== 7'd0)
      $display("FAIL t4_async_clear: got v=%b mr=%b last=%b busy=%b out=%h idx=%0d want all 0",
               o_wv, o_mrdy, o_wlast, o_busy, o_wout, o_widx);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (o_wv !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) $display("FAIL t4_quiet: got %0d cycles with w_valid after reset want 0", errs);
    else passed++;
    drive(1'b0, -1, -1, -1);
    check_full("t4", 64, 1'b1);
  endtask

  task automatic test_start_ignored;
    sel = 1'b0;
    set_abc(1'b0);
    drive(1'b0, 5, 40, -1);
    check_full("t5", 64, 1'b1);
  endtask

`ifdef SHA2_SCHED_ABORT_EN
  task automatic test_abort;
    sel = 1'b0;
    set_abc(1'b0);
    drive(1'b0, -1, -1, 20);
    total++;
    if (!stopped) $display("FAIL t6_reach20: got w_idx 20 not seen want seen");
    else passed++;
    abort_a = 1'b1; w_ready = 1'b1; m_valid = 1'b1; m_data = 64'h5a5a5a5a;
    @(negedge clk);
    abort_a = 1'b0;
    #1;
    total++;
    if (o_wv !== 1'b0 || o_mrdy !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL t6_abort: got w_valid=%b m_ready=%b busy=%b want 0 0 0", o_wv, o_mrdy, o_busy);
    else passed++;
    m_valid = 1'b0;
    drive(1'b0, -1, -1, -1);
    check_full("t6", 64, 1'b1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; m_valid = 1'b0; w_ready = 1'b0;
    m_data = '0; sel = 1'b0;
`ifdef SHA2_SCHED_ABORT_EN
    abort_a = 1'b0;
`endif
    test_reset();
    test_abc256();
    test_stall();
    test_abc512();
    test_reset_mid();
    test_start_ignored();
`ifdef SHA2_SCHED_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
